// File: rtl/sync_filter.sv
// rtl/sync_filter.sv - multi-channel CDC synchronizer with per-channel glitch filter and edge pulses
// Optional sticky change flags are built when SYNC_FILTER_STICKY_EN is defined.
module sync_filter #(
  parameter int                  CHANNELS      = 8,
  parameter int                  STAGES        = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change,
  input  logic [CHANNELS-1:0] event_clr,
  output logic [CHANNELS-1:0] event_flags
);
  localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter: STAGES must be >= 2");
  end

  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync_chain [STAGES];
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] accept;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) sync_chain[k] <= RESET_VALUE;
    end else begin
      sync_chain[0] <= async_in;
      for (int k = 1; k < STAGES; k++) sync_chain[k] <= sync_chain[k-1];
    end
  end

  assign raw = sync_chain[STAGES-1];

  // A channel accepts on the FILTER_CYCLES-th consecutive mismatching cycle.
  always_comb begin
    accept = '0;
    for (int i = 0; i < CHANNELS; i++)
      accept[i] = (raw[i] != sync_out[i]) && (cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      sync_out   <= RESET_VALUE;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if ((raw[i] == sync_out[i]) || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
      sync_out   <= (sync_out & ~accept) | (raw & accept);
      rise_pulse <= accept & raw;
      fall_pulse <= accept & ~raw;
    end
  end

  assign any_change = |(rise_pulse | fall_pulse);

`ifdef SYNC_FILTER_STICKY_EN
  // Set has priority over clear so an event landing with a clear is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      event_flags <= '0;
    else
      event_flags <= (event_flags & ~event_clr) | rise_pulse | fall_pulse;
  end
`else
  logic unused_event_clr;
  assign unused_event_clr = ^event_clr;
  assign event_flags      = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// tb/tb_sync_filter.sv - directed self-checking bench for sync_filter (4 channels, 2 stages, filter 4)
module tb_sync_filter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] async_in;
  logic [3:0] event_clr;
  logic [3:0] sync_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       any_change;
  logic [3:0] event_flags;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SYNC_FILTER_STICKY_EN
  localparam logic [3:0] FLAG_MASK = 4'b1111;
`else
  localparam logic [3:0] FLAG_MASK = 4'b0000;
`endif

  always #5 clk = ~clk;

  sync_filter #(
    .CHANNELS      (4),
    .STAGES        (2),
    .FILTER_CYCLES (4),
    .RESET_VALUE   (4'b0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_in    (async_in),
    .sync_out    (sync_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .any_change  (any_change),
    .event_clr   (event_clr),
    .event_flags (event_flags)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b1;
    async_in  = 4'b0100;
    event_clr = 4'b0000;

    // Reset asserted mid-cycle takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sync_out", sync_out, 4'b0100);
    chk("rst_rise", rise_pulse, 4'b0000);
    chk("rst_fall", fall_pulse, 4'b0000);
    chk("rst_any", 4'(any_change), 4'b0000);
    chk("rst_flags", event_flags, 4'b0000);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("post_rst_any", 4'(any_change), 4'b0000);
    end
    chk("post_rst_sync_out", sync_out, 4'b0100);

    // Clean step on channel 0
    async_in = 4'b0101;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("step_sync_out", sync_out, (c >= 6) ? 4'b0101 : 4'b0100);
      chk("step_rise", rise_pulse, (c == 6) ? 4'b0001 : 4'b0000);
      chk("step_any", 4'(any_change), (c == 6) ? 4'b0001 : 4'b0000);
    end

    // Glitch of three cycles on channel 1
    async_in = 4'b0111;
    repeat (3) tick();
    async_in = 4'b0101;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("glitch3_sync_out", sync_out, 4'b0101);
      chk("glitch3_any", 4'(any_change), 4'b0000);
    end

    // 3 high, 1 low, 3 high: the low cycle restarts the count
    async_in = 4'b0111;
    repeat (3) tick();
    async_in = 4'b0101;
    tick();
    async_in = 4'b0111;
    repeat (3) tick();
    async_in = 4'b0101;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("glitch313_sync_out", sync_out, 4'b0101);
      chk("glitch313_any", 4'(any_change), 4'b0000);
    end

    // Exactly four cycles high is accepted, then the return to 0 is accepted too
    async_in = 4'b0111;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("hold4_sync_out", sync_out, (c >= 6 && c < 10) ? 4'b0111 : 4'b0101);
      chk("hold4_rise", rise_pulse, (c == 6) ? 4'b0010 : 4'b0000);
      chk("hold4_fall", fall_pulse, (c == 10) ? 4'b0010 : 4'b0000);
      if (c == 4) async_in = 4'b0101;
    end

    // Simultaneous rise on ch3 and fall on ch2
    async_in = 4'b1001;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("simul_sync_out", sync_out, (c >= 6) ? 4'b1001 : 4'b0101);
      chk("simul_rise", rise_pulse, (c == 6) ? 4'b1000 : 4'b0000);
      chk("simul_fall", fall_pulse, (c == 6) ? 4'b0100 : 4'b0000);
      chk("simul_any", 4'(any_change), (c == 6) ? 4'b0001 : 4'b0000);
    end
    chk("simul_flags", event_flags, 4'b1111 & FLAG_MASK);

    // Sticky flags: clear all, then clear ch3 in the same cycle as its fall pulse
    event_clr = 4'b1111;
    tick();
    event_clr = 4'b0000;
    chk("clr_all_flags", event_flags, 4'b0000);
    async_in = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("fall3_sync_out", sync_out, (c >= 6) ? 4'b0001 : 4'b1001);
      chk("fall3_flags", event_flags, 4'b0000);
    end
    chk("fall3_pulse", fall_pulse, 4'b1000);
    event_clr = 4'b1000;
    tick();
    event_clr = 4'b0000;
    chk("set_wins_flags", event_flags, 4'b1000 & FLAG_MASK);
    tick();
    chk("flag_holds", event_flags, 4'b1000 & FLAG_MASK);
    event_clr = 4'b1000;
    tick();
    event_clr = 4'b0000;
    chk("isolated_clr_flags", event_flags, 4'b0000);

    // Reset in the middle of a pending ch0 rise
    async_in = 4'b0100;
    repeat (10) tick();
    chk("pre_midrst_sync_out", sync_out, 4'b0100);
    async_in = 4'b0101;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sync_out", sync_out, 4'b0100);
    chk("midrst_any", 4'(any_change), 4'b0000);
    chk("midrst_flags", event_flags, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("after_rst_sync_out", sync_out, (c >= 6) ? 4'b0101 : 4'b0100);
      chk("after_rst_rise", rise_pulse, (c == 6) ? 4'b0001 : 4'b0000);
      chk("after_rst_fall", fall_pulse, 4'b0000);
    end
    chk("after_rst_flags", event_flags, 4'b0001 & FLAG_MASK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
